// File: rtl/gf180mcu_bist_pkg.sv
// Shared types and constants for the AOI22-family BIST controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gf180mcu_bist_pkg;

  localparam int VEC_W      = 4;
  localparam int FAIL_CNT_W = 5;

  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = 5'd31;

  // Stimulus bit positions within the 4-bit vector {A1,A2,B1,B2}
  localparam int BIT_A1 = 3;
  localparam int BIT_A2 = 2;
  localparam int BIT_B1 = 1;
  localparam int BIT_B2 = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    WAIT   = 2'd2,
    SAMPLE = 2'd3
  } bist_state_e;

endpackage

// File: rtl/aoi22_golden.sv
// Golden AOI22 / AO22 response for one stimulus vector.
// Latency: combinational.
// Backpressure: none; pure function of the vector.
module aoi22_golden
  import gf180mcu_bist_pkg::*;
#(
  parameter bit EXPECT_INVERT = 1'b1
) (
  input  logic [VEC_W-1:0] vec,
  output logic             zn
);

  logic ao;

  // AND-OR core, inverted for the AOI22 flavour
  always_comb begin
    ao = (vec[BIT_A1] & vec[BIT_A2]) | (vec[BIT_B1] & vec[BIT_B2]);
    zn = EXPECT_INVERT ? ~ao : ao;
  end

endmodule

// File: rtl/aoi22_bist_ctrl.sv
// Exhaustive-vector BIST controller for an AOI22 cell under test.
// Latency: DONE 1 + 16*NUM_PASSES*(SETTLE_CYCLES+1) cycles after START is accepted.
// Backpressure: none; START is only honoured while idle, ignored while BUSY.
module aoi22_bist_ctrl
  import gf180mcu_bist_pkg::*;
#(
  parameter int NUM_PASSES    = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter bit EXPECT_INVERT = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [VEC_W-1:0]      FAIL_VEC,
  output logic [FAIL_CNT_W-1:0] FAIL_CNT,
  output logic                  A1,
  output logic                  A2,
  output logic                  B1,
  output logic                  B2,
  input  logic                  ZN,
  inout  wire                   VDD,
  inout  wire                   VSS
);

  // A vector occupies SETTLE_CYCLES+1 cycles and the last one is always SAMPLE,
  // so the counter holds the number of WAIT cycles still to go after DRIVE.
  localparam bit              SETTLE_ZERO = (SETTLE_CYCLES == 0);
  localparam logic [3:0]      SETTLE_LOAD = SETTLE_ZERO ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      LAST_PASS   = 4'(NUM_PASSES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC   = '1;

  bist_state_e state_q, state_d;

  logic [VEC_W-1:0]      vec_q, vec_d;
  logic [3:0]            pass_idx_q, pass_idx_d;
  logic [3:0]            settle_q, settle_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [VEC_W-1:0]      fail_vec_q, fail_vec_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  logic golden_zn;
  logic zn_mismatch;
  logic drive_en;
  logic sample_en;
  logic last_vec;
  logic last_pass;

  // Power pins carry no logic; fold them into a sink so they are not dangling
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  aoi22_golden #(
    .EXPECT_INVERT (EXPECT_INVERT)
  ) u_golden (
    .vec (vec_q),
    .zn  (golden_zn)
  );

  assign last_vec    = (vec_q == LAST_VEC);
  assign last_pass   = (pass_idx_q == LAST_PASS);
  // X/Z on ZN must also count as a failure, hence case inequality
  assign zn_mismatch = sample_en && (ZN !== golden_zn);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: DRIVE/WAIT are skipped when there is no settle time
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (SETTLE_ZERO) state_d = SAMPLE;
          else             state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == 4'd0) state_d = SAMPLE;
        else                  state_d = WAIT;
      end
      WAIT: begin
        if (settle_q == 4'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (last_vec && last_pass) state_d = IDLE;
        else if (SETTLE_ZERO)      state_d = SAMPLE;
        else                       state_d = DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    drive_en  = (state_q != IDLE);
    sample_en = (state_q == SAMPLE);
    BUSY      = drive_en;
    A1        = drive_en & vec_q[BIT_A1];
    A2        = drive_en & vec_q[BIT_A2];
    B1        = drive_en & vec_q[BIT_B1];
    B2        = drive_en & vec_q[BIT_B2];
  end

  // Datapath: vector sequencing, settle counting and result accumulation
  always_comb begin
    vec_d      = vec_q;
    pass_idx_d = pass_idx_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    fail_cnt_d = fail_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          vec_d      = '0;
          pass_idx_d = 4'd0;
          settle_d   = SETTLE_LOAD;
          pass_d     = 1'b0;
          fail_vec_d = '0;
          fail_cnt_d = '0;
        end
      end
      DRIVE: begin
        settle_d = settle_q;
      end
      WAIT: begin
        settle_d = settle_q - 4'd1;
      end
      SAMPLE: begin
        if (zn_mismatch) begin
          if (fail_cnt_q == '0)          fail_vec_d = vec_q;
          if (fail_cnt_q != FAIL_CNT_MAX) fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
        end
        settle_d = SETTLE_LOAD;
        if (!last_vec) begin
          vec_d = vec_q + VEC_W'(1);
        end else if (!last_pass) begin
          vec_d      = '0;
          pass_idx_d = pass_idx_q + 4'd1;
        end else begin
          // Final sample of the run: verdict includes this cycle's compare
          vec_d  = '0;
          done_d = 1'b1;
          pass_d = (fail_cnt_d == '0);
        end
      end
      default: vec_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      vec_q      <= '0;
      pass_idx_q <= 4'd0;
      settle_q   <= 4'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      vec_q      <= vec_d;
      pass_idx_q <= pass_idx_d;
      settle_q   <= settle_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign FAIL_VEC = fail_vec_q;
  assign FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_aoi22_bist_ctrl.sv
// Bench for aoi22_bist_ctrl: three parameterisations driven against a faultable CUT model.
// Expected run results are queued at START acceptance and checked by a negedge monitor.
module tb_aoi22_bist_ctrl;

  typedef struct {
    int start_cyc;
    int done_cyc;
    int cnt;
    int fvec;
    bit pass;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] rst   = 3'b111;
  logic [2:0] start = 3'b000;
  logic [2:0] busy, done, pass_o, a1, a2, b1, b2, zn;
  logic [3:0] fail_vec [3];
  logic [4:0] fail_cnt [3];
  logic [15:0] mask_cur [3];

  exp_t sb [3][$];
  int   last_cnt  [3];
  int   last_vec  [3];
  bit   last_pass [3];

  wire vdd = 1'b1;
  wire vss = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int np_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int st_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  function automatic bit ei_of(input int i);
    return (i == 2) ? 1'b0 : 1'b1;
  endfunction

  // Truth table of the cell from arithmetic on the vector index
  function automatic bit ideal_zn(input int v, input bit inv);
    int a, b, c, d;
    bit ao;
    a = (v / 8) % 2;
    b = (v / 4) % 2;
    c = (v / 2) % 2;
    d = v % 2;
    ao = (a * b + c * d) > 0;
    return inv ? !ao : ao;
  endfunction

  // CUT model: ideal cell for this instance, with per-vector output flips
  for (genvar g = 0; g < 3; g++) begin : g_cut
    assign zn[g] = ideal_zn(int'({a1[g], a2[g], b1[g], b2[g]}), ei_of(g))
                   ^ mask_cur[g][{a1[g], a2[g], b1[g], b2[g]}];
  end

  aoi22_bist_ctrl dut0 (
    .CLK(clk), .RST(rst[0]), .START(start[0]), .BUSY(busy[0]), .DONE(done[0]),
    .PASS(pass_o[0]), .FAIL_VEC(fail_vec[0]), .FAIL_CNT(fail_cnt[0]),
    .A1(a1[0]), .A2(a2[0]), .B1(b1[0]), .B2(b2[0]), .ZN(zn[0]), .VDD(vdd), .VSS(vss)
  );

  aoi22_bist_ctrl #(.NUM_PASSES(4)) dut1 (
    .CLK(clk), .RST(rst[1]), .START(start[1]), .BUSY(busy[1]), .DONE(done[1]),
    .PASS(pass_o[1]), .FAIL_VEC(fail_vec[1]), .FAIL_CNT(fail_cnt[1]),
    .A1(a1[1]), .A2(a2[1]), .B1(b1[1]), .B2(b2[1]), .ZN(zn[1]), .VDD(vdd), .VSS(vss)
  );

  aoi22_bist_ctrl #(.SETTLE_CYCLES(0), .EXPECT_INVERT(1'b0)) dut2 (
    .CLK(clk), .RST(rst[2]), .START(start[2]), .BUSY(busy[2]), .DONE(done[2]),
    .PASS(pass_o[2]), .FAIL_VEC(fail_vec[2]), .FAIL_CNT(fail_cnt[2]),
    .A1(a1[2]), .A2(a2[2]), .B1(b1[2]), .B2(b2[2]), .ZN(zn[2]), .VDD(vdd), .VSS(vss)
  );

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, i, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Run outcome from the fault mask: every flagged vector fails once per pass
  function automatic exp_t model(input int i, input int t, input logic [15:0] mask);
    exp_t e;
    int raw;
    raw         = np_of(i) * $countones(mask);
    e.start_cyc = t;
    e.done_cyc  = t + 1 + 16 * np_of(i) * (st_of(i) + 1);
    e.cnt       = (raw > 31) ? 31 : raw;
    e.pass      = (raw == 0);
    e.fvec      = 0;
    for (int v = 15; v >= 0; v--) if (mask[v]) e.fvec = v;
    return e;
  endfunction

  function automatic logic [15:0] stuck_mask(input int i, input bit val);
    logic [15:0] m;
    for (int v = 0; v < 16; v++) m[v] = (ideal_zn(v, ei_of(i)) != val);
    return m;
  endfunction

  function automatic logic [15:0] model_mask(input int i, input bit inv);
    logic [15:0] m;
    for (int v = 0; v < 16; v++) m[v] = (ideal_zn(v, ei_of(i)) != ideal_zn(v, inv));
    return m;
  endfunction

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    m = 16'($urandom) & 16'($urandom);
    if ($urandom_range(0, 3) == 0) m = '0;
    return m;
  endfunction

  task automatic drive_start(input int i, input int ncyc, input logic [15:0] mask);
    for (int k = 0; k < ncyc; k++) begin
      tick();
      start[i] = 1'b1;
      if (sb[i].size() == 0 && !rst[i]) begin
        mask_cur[i] = mask;
        sb[i].push_back(model(i, cyc, mask));
        last_pass[i] = 1'b0;
        last_cnt[i]  = 0;
        last_vec[i]  = 0;
      end
    end
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int budget;
    budget = 400;
    while (sb[i].size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (sb[i].size() != 0) begin
      chk("done_timeout", i, 0, 1);
      sb[i].delete();
    end
  endtask

  task automatic run_one(input int i, input logic [15:0] mask);
    drive_start(i, 1, mask);
    wait_done(i);
  endtask

  task automatic seq0();
    run_one(0, 16'h0000);
    run_one(0, stuck_mask(0, 1'b0));
    run_one(0, stuck_mask(0, 1'b1));
    // second START pulse lands while busy
    drive_start(0, 1, 16'h0000);
    repeat (8) tick();
    drive_start(0, 1, 16'hFFFF);
    wait_done(0);
    // START held across the DONE cycle
    drive_start(0, 1, stuck_mask(0, 1'b1));
    repeat (45) tick();
    drive_start(0, 5, 16'h0000);
    wait_done(0);
    // reset in the middle of a run
    drive_start(0, 1, 16'h0000);
    repeat (19) tick();
    rst[0] = 1'b1;
    sb[0].delete();
    last_pass[0] = 1'b0;
    last_cnt[0]  = 0;
    last_vec[0]  = 0;
    tick();
    rst[0] = 1'b0;
    repeat (40) tick();
    run_one(0, 16'h0000);
    for (int k = 0; k < 6; k++) run_one(0, rand_mask());
  endtask

  task automatic seq1();
    run_one(1, stuck_mask(1, 1'b0));
    run_one(1, rand_mask());
    run_one(1, 16'h0000);
  endtask

  task automatic seq2();
    run_one(2, 16'h0000);
    run_one(2, model_mask(2, 1'b1));
    for (int k = 0; k < 4; k++) run_one(2, rand_mask());
  endtask

  exp_t mon_e;
  bit   mon_have, mon_busy, mon_done;
  int   mon_vec;

  // Monitor: compare every instance each cycle against the head of its queue
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 3; i++) begin
        mon_have = (sb[i].size() != 0);
        if (mon_have) mon_e = sb[i][0];
        mon_busy = mon_have && (cyc > mon_e.start_cyc) && (cyc < mon_e.done_cyc);
        mon_done = mon_have && (cyc == mon_e.done_cyc);
        chk("busy", i, int'(busy[i]), int'(mon_busy));
        chk("done", i, int'(done[i]), int'(mon_done));
        if (mon_busy) begin
          mon_vec = ((cyc - mon_e.start_cyc - 1) / (st_of(i) + 1)) % 16;
          chk("stim_vec", i, int'({a1[i], a2[i], b1[i], b2[i]}), mon_vec);
          chk("pass_cleared", i, int'(pass_o[i]), 0);
          if (cyc == mon_e.start_cyc + 1) begin
            chk("cnt_cleared", i, int'(fail_cnt[i]), 0);
            chk("fvec_cleared", i, int'(fail_vec[i]), 0);
          end
        end else begin
          chk("stim_idle", i, int'({a1[i], a2[i], b1[i], b2[i]}), 0);
          if (mon_done) begin
            chk("pass", i, int'(pass_o[i]), int'(mon_e.pass));
            chk("fail_cnt", i, int'(fail_cnt[i]), mon_e.cnt);
            chk("fail_vec", i, int'(fail_vec[i]), mon_e.fvec);
            last_pass[i] = mon_e.pass;
            last_cnt[i]  = mon_e.cnt;
            last_vec[i]  = mon_e.fvec;
            void'(sb[i].pop_front());
          end else begin
            chk("pass_hold", i, int'(pass_o[i]), int'(last_pass[i]));
            chk("cnt_hold", i, int'(fail_cnt[i]), last_cnt[i]);
            chk("fvec_hold", i, int'(fail_vec[i]), last_vec[i]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      mask_cur[i]  = '0;
      last_cnt[i]  = 0;
      last_vec[i]  = 0;
      last_pass[i] = 1'b0;
    end
    repeat (3) tick();
    rst = 3'b000;
    fork
      seq0();
      seq1();
      seq2();
    join
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

endmodule
